// File: rtl/m_cache_ctrl_if.sv
// CPU, cache-array and memory signals between the cache controller and its neighbours.
// The controller takes the slave modport; the environment drives the master side.
`ifndef EADDR_WIDTH
`define EADDR_WIDTH 32
`endif

interface m_cache_ctrl_if #(
  parameter int unsigned ADDR_W = `EADDR_WIDTH,
  parameter int unsigned CNT_W  = 32
);
  logic              i_rd;
  logic              i_wr;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic              o_ready;
  logic              o_rvalid;
  logic [31:0]       o_rdata;
  logic              o_wdone;
  logic [ADDR_W-1:0] o_c_raddr;
  logic [ADDR_W-1:0] o_c_waddr;
  logic              o_c_we;
  logic [31:0]       o_c_data;
  logic              o_c_bwe;
  logic [127:0]      o_c_bdata;
  logic [127:0]      i_c_data;
  logic              i_c_hit;
  logic [1:0]        i_c_bindex;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_gnt;
  logic              i_mem_rvalid;
  logic [31:0]       i_mem_rdata;
  logic [CNT_W-1:0]  o_hit_cnt;
  logic [CNT_W-1:0]  o_miss_cnt;

  modport master (
    output i_rd, i_wr, i_addr, i_wdata, i_c_data, i_c_hit, i_c_bindex,
           i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_ready, o_rvalid, o_rdata, o_wdone, o_c_raddr, o_c_waddr, o_c_we,
           o_c_data, o_c_bwe, o_c_bdata, o_mem_req, o_mem_we, o_mem_addr,
           o_mem_wdata, o_hit_cnt, o_miss_cnt
  );

  modport slave (
    input  i_rd, i_wr, i_addr, i_wdata, i_c_data, i_c_hit, i_c_bindex,
           i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_ready, o_rvalid, o_rdata, o_wdone, o_c_raddr, o_c_waddr, o_c_we,
           o_c_data, o_c_bwe, o_c_bdata, o_mem_req, o_mem_we, o_mem_addr,
           o_mem_wdata, o_hit_cnt, o_miss_cnt
  );
endinterface

// File: rtl/m_cache_ctrl.sv
// Blocking cache controller: read lookup with 4-beat line fill on miss,
// write-through no-allocate writes, hit/miss statistics counters.
`ifndef EADDR_WIDTH
`define EADDR_WIDTH 32
`endif

module m_cache_ctrl #(
  parameter int unsigned ADDR_W = `EADDR_WIDTH,
  parameter int unsigned CNT_W  = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  m_cache_ctrl_if.slave bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEAT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL_CMD,
    S_FILL_DATA,
    S_INSTALL,
    S_WRITE
  } state_e;

  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [WORD_W-1:0]            wdata_q, wdata_d;
  logic [BEAT_W-1:0]            beat_q, beat_d;
  logic [3:0][WORD_W-1:0]       lbuf_q, lbuf_d;
  logic [CNT_W-1:0]             hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]             miss_cnt_q, miss_cnt_d;
  logic [ADDR_W-1:0]            line_addr;

  assign line_addr      = {addr_q[ADDR_W-1:4], 4'b0000};
  assign bus.o_hit_cnt  = hit_cnt_q;
  assign bus.o_miss_cnt = miss_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      beat_q     <= '0;
      lbuf_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      beat_q     <= beat_d;
      lbuf_q     <= lbuf_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state and strobe generation; anything not driven by the current state stays 0.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    beat_d          = beat_q;
    lbuf_d          = lbuf_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    bus.o_ready     = 1'b0;
    bus.o_rvalid    = 1'b0;
    bus.o_rdata     = '0;
    bus.o_wdone     = 1'b0;
    bus.o_c_raddr   = addr_q;
    bus.o_c_waddr   = '0;
    bus.o_c_we      = 1'b0;
    bus.o_c_data    = '0;
    bus.o_c_bwe     = 1'b0;
    bus.o_c_bdata   = '0;
    bus.o_mem_req   = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        bus.o_ready   = 1'b1;
        bus.o_c_raddr = bus.i_addr;
        if (bus.i_wr) begin
          // Write-through: the array only takes the word if the line is resident.
          addr_d        = bus.i_addr;
          wdata_d       = bus.i_wdata;
          bus.o_c_we    = 1'b1;
          bus.o_c_waddr = bus.i_addr;
          bus.o_c_data  = bus.i_wdata;
          state_d       = S_WRITE;
        end else if (bus.i_rd) begin
          addr_d  = bus.i_addr;
          wdata_d = bus.i_wdata;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (bus.i_c_hit) begin
          bus.o_rvalid = 1'b1;
          bus.o_rdata  = WORD_W'(bus.i_c_data >> {bus.i_c_bindex, 5'd0});
          hit_cnt_d    = hit_cnt_q + CNT_W'(1);
          state_d      = S_IDLE;
        end else begin
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d    = S_FILL_CMD;
        end
      end

      S_FILL_CMD: begin
        bus.o_mem_req  = 1'b1;
        bus.o_mem_addr = line_addr;
        if (bus.i_mem_gnt) begin
          beat_d  = '0;
          state_d = S_FILL_DATA;
        end
      end

      S_FILL_DATA: begin
        if (bus.i_mem_rvalid) begin
          lbuf_d[beat_q] = bus.i_mem_rdata;
          beat_d         = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(3)) begin
            state_d = S_INSTALL;
          end
        end
      end

      S_INSTALL: begin
        bus.o_c_bwe   = 1'b1;
        bus.o_c_waddr = line_addr;
        bus.o_c_bdata = lbuf_q;
        bus.o_rvalid  = 1'b1;
        bus.o_rdata   = lbuf_q[addr_q[3:2]];
        state_d       = S_IDLE;
      end

      S_WRITE: begin
        bus.o_mem_req   = 1'b1;
        bus.o_mem_we    = 1'b1;
        bus.o_mem_addr  = addr_q;
        bus.o_mem_wdata = wdata_q;
        if (bus.i_mem_gnt) begin
          bus.o_wdone = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_m_cache_ctrl.sv
// Directed bench for m_cache_ctrl: hit, miss fill, write-through, rd+wr priority,
// reset during fill and hit-counter wrap (counters narrowed to 4 bits).
module tb_m_cache_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [31:0]  a_w [4];
  logic [127:0] line_a;
  logic [127:0] line_h;

  m_cache_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  m_cache_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hit(input logic [31:0] a);
    bus.i_rd   = 1'b1;
    bus.i_addr = a;
    tick();
    bus.i_rd    = 1'b0;
    bus.i_c_hit = 1'b1;
    tick();
    bus.i_c_hit = 1'b0;
  endtask

  initial begin
    a_w[0] = 32'hA000_0000; a_w[1] = 32'hA111_1111;
    a_w[2] = 32'hA222_2222; a_w[3] = 32'hA333_3333;
    line_a = {a_w[3], a_w[2], a_w[1], a_w[0]};
    line_h = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};

    rst_n = 1'b0;
    bus.i_rd = 1'b0; bus.i_wr = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_c_data = '0; bus.i_c_hit = 1'b0; bus.i_c_bindex = '0;
    bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0;
    tick(); tick();
    chk("rst_ready",   128'(bus.o_ready), 128'(1'b1));
    chk("rst_hitcnt",  128'(bus.o_hit_cnt), 128'(4'd0));
    chk("rst_misscnt", 128'(bus.o_miss_cnt), 128'(4'd0));
    chk("rst_memreq",  128'(bus.o_mem_req), 128'(1'b0));
    rst_n = 1'b1;
    tick();

    // Hit on preloaded line 0x100, word 2
    bus.i_rd = 1'b1; bus.i_addr = 32'h108;
    #1;
    chk("hit_raddr_idle", 128'(bus.o_c_raddr), 128'(32'h108));
    tick();
    bus.i_rd = 1'b0; bus.i_c_hit = 1'b1; bus.i_c_data = line_h; bus.i_c_bindex = 2'd2;
    #1;
    chk("hit_rvalid", 128'(bus.o_rvalid), 128'(1'b1));
    chk("hit_rdata",  128'(bus.o_rdata), 128'(32'h2222_0002));
    chk("hit_ready",  128'(bus.o_ready), 128'(1'b0));
    tick();
    bus.i_c_hit = 1'b0;
    #1;
    chk("hit_cnt1",    128'(bus.o_hit_cnt), 128'(4'd1));
    chk("hit_rv_drop", 128'(bus.o_rvalid), 128'(1'b0));

    // Miss on 0x204 with delayed grant and a bubble between beats
    bus.i_rd = 1'b1; bus.i_addr = 32'h204;
    tick();
    bus.i_rd = 1'b0; bus.i_addr = 32'h0;
    #1;
    chk("miss_no_rvalid", 128'(bus.o_rvalid), 128'(1'b0));
    tick();
    chk("miss_cnt1",    128'(bus.o_miss_cnt), 128'(4'd1));
    chk("fill_req",     128'(bus.o_mem_req), 128'(1'b1));
    chk("fill_we",      128'(bus.o_mem_we), 128'(1'b0));
    chk("fill_addr",    128'(bus.o_mem_addr), 128'(32'h200));
    tick();
    chk("fill_addr_hold", 128'(bus.o_mem_addr), 128'(32'h200));
    tick();
    bus.i_mem_gnt = 1'b1;
    #1;
    chk("fill_req_gnt", 128'(bus.o_mem_req), 128'(1'b1));
    tick();
    bus.i_mem_gnt = 1'b0;
    #1;
    chk("fill_req_drop", 128'(bus.o_mem_req), 128'(1'b0));
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = a_w[0];
    tick();
    bus.i_mem_rvalid = 1'b0;
    tick();
    for (int b = 1; b < 4; b++) begin
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = a_w[b];
      tick();
    end
    bus.i_mem_rvalid = 1'b0;
    #1;
    chk("inst_bwe",    128'(bus.o_c_bwe), 128'(1'b1));
    chk("inst_we",     128'(bus.o_c_we), 128'(1'b0));
    chk("inst_waddr",  128'(bus.o_c_waddr), 128'(32'h200));
    chk("inst_bdata",  bus.o_c_bdata, line_a);
    chk("inst_rvalid", 128'(bus.o_rvalid), 128'(1'b1));
    chk("inst_rdata",  128'(bus.o_rdata), 128'(a_w[1]));
    tick();
    chk("inst_bwe_drop", 128'(bus.o_c_bwe), 128'(1'b0));
    chk("inst_ready",    128'(bus.o_ready), 128'(1'b1));

    // Re-read 0x204 now hits
    bus.i_rd = 1'b1; bus.i_addr = 32'h204;
    tick();
    bus.i_rd = 1'b0; bus.i_c_hit = 1'b1; bus.i_c_data = line_a; bus.i_c_bindex = 2'd1;
    #1;
    chk("reread_rdata", 128'(bus.o_rdata), 128'(a_w[1]));
    tick();
    bus.i_c_hit = 1'b0;
    chk("reread_hitcnt",  128'(bus.o_hit_cnt), 128'(4'd2));
    chk("reread_misscnt", 128'(bus.o_miss_cnt), 128'(4'd1));

    // Write-through to 0x300
    bus.i_wr = 1'b1; bus.i_addr = 32'h300; bus.i_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_cwe",   128'(bus.o_c_we), 128'(1'b1));
    chk("wr_waddr", 128'(bus.o_c_waddr), 128'(32'h300));
    chk("wr_cdata", 128'(bus.o_c_data), 128'(32'hDEAD_BEEF));
    chk("wr_bwe",   128'(bus.o_c_bwe), 128'(1'b0));
    tick();
    bus.i_wr = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    #1;
    chk("wr_memreq",  128'(bus.o_mem_req), 128'(1'b1));
    chk("wr_memwe",   128'(bus.o_mem_we), 128'(1'b1));
    chk("wr_memaddr", 128'(bus.o_mem_addr), 128'(32'h300));
    chk("wr_memdata", 128'(bus.o_mem_wdata), 128'(32'hDEAD_BEEF));
    chk("wr_nodone",  128'(bus.o_wdone), 128'(1'b0));
    tick();
    chk("wr_memwe_hold", 128'(bus.o_mem_we), 128'(1'b1));
    bus.i_mem_gnt = 1'b1;
    #1;
    chk("wr_wdone", 128'(bus.o_wdone), 128'(1'b1));
    tick();
    bus.i_mem_gnt = 1'b0;
    #1;
    chk("wr_wdone_drop", 128'(bus.o_wdone), 128'(1'b0));
    chk("wr_ready",      128'(bus.o_ready), 128'(1'b1));

    // Read and write together: write wins, counters untouched
    bus.i_rd = 1'b1; bus.i_wr = 1'b1; bus.i_addr = 32'h104; bus.i_wdata = 32'h1234_5678;
    #1;
    chk("both_cwe", 128'(bus.o_c_we), 128'(1'b1));
    tick();
    bus.i_rd = 1'b0; bus.i_wr = 1'b0; bus.i_c_hit = 1'b1;
    #1;
    chk("both_memwe",   128'(bus.o_mem_we), 128'(1'b1));
    chk("both_norval",  128'(bus.o_rvalid), 128'(1'b0));
    bus.i_mem_gnt = 1'b1;
    tick();
    bus.i_mem_gnt = 1'b0; bus.i_c_hit = 1'b0;
    chk("both_hitcnt",  128'(bus.o_hit_cnt), 128'(4'd2));
    chk("both_misscnt", 128'(bus.o_miss_cnt), 128'(4'd1));

    // Reset after two fill beats aborts the fill
    bus.i_rd = 1'b1; bus.i_addr = 32'h408;
    tick();
    bus.i_rd = 1'b0;
    tick();
    bus.i_mem_gnt = 1'b1;
    tick();
    bus.i_mem_gnt = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = a_w[b];
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstfill_bwe",   128'(bus.o_c_bwe), 128'(1'b0));
    chk("rstfill_ready", 128'(bus.o_ready), 128'(1'b1));
    chk("rstfill_rval",  128'(bus.o_rvalid), 128'(1'b0));
    chk("rstfill_miss",  128'(bus.o_miss_cnt), 128'(4'd0));
    tick();
    chk("stray_ready", 128'(bus.o_ready), 128'(1'b1));
    tick();
    bus.i_mem_rvalid = 1'b0;
    chk("stray_bwe",   128'(bus.o_c_bwe), 128'(1'b0));
    chk("stray_rval",  128'(bus.o_rvalid), 128'(1'b0));

    // Hit counter wraps after 2^CNT_W hits
    for (int n = 0; n < 15; n++) do_hit(32'h108);
    chk("wrap_pre",  128'(bus.o_hit_cnt), 128'(4'hF));
    do_hit(32'h108);
    chk("wrap_zero", 128'(bus.o_hit_cnt), 128'(4'h0));
    chk("wrap_miss", 128'(bus.o_miss_cnt), 128'(4'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
